// File: rtl/fpu_imant_div.sv
// Iterative radix-4 restoring mantissa divider: Q = floor(S * 2^(CMantLen+1) / D).
// Two quotient bits per enabled clock; sticky flags a nonzero remainder for rounding.
module fpu_imant_div #(
  parameter int unsigned CMantLen = 28
) (
  input  logic                AClkH,
  input  logic                AResetHN,
  input  logic                AClkHEn,
  input  logic [CMantLen-1:0] ADataS,
  input  logic [CMantLen-1:0] ADataD,
  input  logic                AStart,
  output logic [CMantLen+1:0] ADataR,
  output logic                ASticky,
  output logic                ADivZero,
  output logic                AOvf,
  output logic                ABusy,
  output logic                AWrEn
);

  localparam int unsigned RemW   = CMantLen + 2;
  localparam int unsigned NSteps = (CMantLen + 2) / 2;

  logic [RemW-1:0]     rem_q, rem_d;
  logic [CMantLen-1:0] dr_q, dr_d;
  logic [CMantLen-1:0] quot_q, quot_d;
  logic [NSteps-1:0]   step_q, step_d;
  logic                dz_q, dz_d;
  logic                ov_q, ov_d;

  logic [RemW-1:0] dr_ext;
  logic [RemW-1:0] rem_s1, rem_b, rem_s2, rem_c;
  logic            q_a, q_b;
  logic [RemW-1:0] quot_next;

  // Two back-to-back restoring iterations on the current remainder.
  always_comb begin
    dr_ext    = {2'b00, dr_q};
    q_a       = (rem_q >= dr_ext);
    rem_s1    = q_a ? (rem_q - dr_ext) : rem_q;
    rem_b     = rem_s1 << 1;
    q_b       = (rem_b >= dr_ext);
    rem_s2    = q_b ? (rem_b - dr_ext) : rem_b;
    rem_c     = rem_s2 << 1;
    quot_next = {quot_q, q_a, q_b};
  end

  always_comb begin
    rem_d  = rem_q;
    dr_d   = dr_q;
    quot_d = quot_q;
    step_d = step_q;
    dz_d   = dz_q;
    ov_d   = ov_q;
    if (AClkHEn) begin
      // A start always wins, which aborts any operation in flight.
      if (AStart) begin
        rem_d  = {2'b00, ADataS};
        dr_d   = ADataD;
        quot_d = '0;
        step_d = NSteps'(1) << (NSteps - 1);
        dz_d   = (ADataD == '0);
        ov_d   = ({1'b0, ADataS} >= {ADataD, 1'b0});
      end else if (|step_q) begin
        rem_d  = rem_c;
        quot_d = quot_next[CMantLen-1:0];
        step_d = step_q >> 1;
      end
    end
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      rem_q  <= '0;
      dr_q   <= '0;
      quot_q <= '0;
      step_q <= '0;
      dz_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dr_q   <= dr_d;
      quot_q <= quot_d;
      step_q <= step_d;
      dz_q   <= dz_d;
      ov_q   <= ov_d;
    end
  end

  // Result is combinational from the final step so it appears with the strobe.
  always_comb begin
    ABusy    = |step_q;
    AWrEn    = step_q[0];
    ADataR   = '0;
    ASticky  = 1'b0;
    ADivZero = 1'b0;
    AOvf     = 1'b0;
    if (step_q[0]) begin
      if (dz_q) begin
        ADataR   = '1;
        ADivZero = 1'b1;
      end else if (ov_q) begin
        ADataR  = '1;
        ASticky = 1'b1;
        AOvf    = 1'b1;
      end else begin
        ADataR  = quot_next;
        ASticky = |rem_c;
      end
    end
  end

endmodule

// File: tb/tb_fpu_imant_div.sv
// Self-checking bench for fpu_imant_div: directed corner cases, abort, reset, clock-enable
// gating and randomized operands against an arithmetic reference model.
module tb_fpu_imant_div;

  localparam int unsigned W      = 28;
  localparam int unsigned RW     = W + 2;
  localparam int unsigned NSteps = RW / 2;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          en      = 1'b1;
  logic          start   = 1'b0;
  logic [W-1:0]  s_in    = '0;
  logic [W-1:0]  d_in    = '0;
  logic [RW-1:0] data_r;
  logic          sticky, div_zero, ovf, busy, wr_en;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  fpu_imant_div #(.CMantLen(W)) dut (
    .AClkH    (clk),
    .AResetHN (rst_n),
    .AClkHEn  (en),
    .ADataS   (s_in),
    .ADataD   (d_in),
    .AStart   (start),
    .ADataR   (data_r),
    .ASticky  (sticky),
    .ADivZero (div_zero),
    .AOvf     (ovf),
    .ABusy    (busy),
    .AWrEn    (wr_en)
  );

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain integer division of the scaled dividend, with the override rules.
  task automatic ref_model(input logic [W-1:0] s, input logic [W-1:0] d,
                           output logic [RW-1:0] q, output logic st, output logic dz,
                           output logic ov);
    longint unsigned num;
    num = 64'(s) << (W + 1);
    dz  = (d == '0);
    ov  = !dz && (64'(s) >= 2 * 64'(d));
    if (dz) begin
      q  = '1;
      st = 1'b0;
    end else if (ov) begin
      q  = '1;
      st = 1'b1;
    end else begin
      q  = RW'(num / 64'(d));
      st = (num % 64'(d)) != 0;
    end
  endtask

  // Runs one operation, counting enabled edges after the start edge, checking every cycle.
  task automatic drive_op(input logic [W-1:0] s, input logic [W-1:0] d, input bit rnd_en);
    logic [RW-1:0] eq;
    logic est, edz, eov;
    int n;
    int cyc;
    ref_model(s, d, eq, est, edz, eov);
    @(negedge clk);
    s_in  = s;
    d_in  = d;
    start = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_in  = W'($urandom);
    d_in  = W'($urandom);
    n     = 0;
    cyc   = 0;
    while (n < int'(NSteps)) begin
      check("busy", 64'(busy), 64'(1));
      check("wr_en", 64'(wr_en), 64'(n == int'(NSteps) - 1));
      if (wr_en) begin
        check("data", 64'(data_r), 64'(eq));
        check("sticky", 64'(sticky), 64'(est));
        check("div_zero", 64'(div_zero), 64'(edz));
        check("ovf", 64'(ovf), 64'(eov && !edz));
      end else begin
        check("data_idle", 64'(data_r), 64'(0));
        check("flags_idle", 64'({sticky, div_zero, ovf}), 64'(0));
      end
      en = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (en) n++;
      cyc++;
      if (cyc > 400) begin
        check("op_timeout", 64'(cyc), 64'(0));
        break;
      end
    end
    en = 1'b1;
    check("busy_end", 64'(busy), 64'(0));
    check("wr_en_end", 64'(wr_en), 64'(0));
  endtask

  // Starts an operation and runs k cycles of it, expecting no strobe yet.
  task automatic partial(input logic [W-1:0] s, input logic [W-1:0] d, input int k);
    @(negedge clk);
    s_in  = s;
    d_in  = d;
    start = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("part_wr_en", 64'(wr_en), 64'(0));
      check("part_busy", 64'(busy), 64'(1));
    end
  endtask

  logic [W-1:0] dir_s [8];
  logic [W-1:0] dir_d [8];

  initial begin
    dir_s = '{28'h8000000, 28'hC000000, 28'h8000000, 28'h1234567, 28'hFFFFFFF,
              28'hFFFFFFF, 28'h8000000, 28'hFFFFFFE};
    dir_d = '{28'h8000000, 28'h8000000, 28'hC000000, 28'h0000000, 28'h7FFFFFF,
              28'hFFFFFFF, 28'hFFFFFFF, 28'h7FFFFFF};

    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_data", 64'(data_r), 64'(0));
    check("rst_flags", 64'({sticky, div_zero, ovf}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) drive_op(dir_s[i], dir_d[i], 1'b0);
    for (int i = 0; i < 8; i++) drive_op(dir_s[i], dir_d[i], 1'b1);

    // Abort: B started in cycle 7 of A must be the only result.
    partial(28'hC000000, 28'h8000000, 6);
    drive_op(28'h8000000, 28'hC000000, 1'b0);

    // Reset mid-operation, then confirm no stray strobe.
    partial(28'h9ABCDEF, 28'hA000000, 5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_wr_en", 64'(wr_en), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("post_rst_wr_en", 64'(wr_en), 64'(0));
      check("post_rst_busy", 64'(busy), 64'(0));
    end

    // Reset during the strobe cycle clears outputs asynchronously.
    partial(28'hFFFFFFF, 28'h8000000, int'(NSteps) - 1);
    @(negedge clk);
    check("pre_rst_wr_en", 64'(wr_en), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("strobe_rst_wr_en", 64'(wr_en), 64'(0));
    check("strobe_rst_data", 64'(data_r), 64'(0));
    check("strobe_rst_flags", 64'({sticky, div_zero, ovf}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 2500; i++) begin
      drive_op(W'(32'h8000000 | ($urandom & 32'h7FFFFFF)),
               W'(32'h8000000 | ($urandom & 32'h7FFFFFF)), i < 100);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
